// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory, decode and execute signals of the fetch sequencer
interface fetch_sequencer_if #(
  parameter int PC_W = 64
);
  logic            imem_rd;
  logic [PC_W-1:0] imem_addr;
  logic [7:0]      imem_rdata;
  logic [31:0]     instr;
  logic [PC_W-1:0] instr_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic            ex_done;
  logic            pc_src;
  logic [PC_W-1:0] branch_addr;
  logic            halted;
  logic            fault;
  logic [31:0]     retired;
  modport master (
    output imem_rd, imem_addr, instr, instr_pc, instr_valid, halted, fault, retired,
    input  imem_rdata, instr_ready, ex_done, pc_src, branch_addr
  );
  modport slave (
    input  imem_rd, imem_addr, instr, instr_pc, instr_valid, halted, fault, retired,
    output imem_rdata, instr_ready, ex_done, pc_src, branch_addr
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multicycle byte-wide instruction fetch with decode handshake and PC update
module fetch_sequencer #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic               clk,
  input logic               reset,
  fetch_sequencer_if.master bus
);
  typedef enum logic [2:0] {FETCH, LAST, ISSUE, WAIT, HALT} state_t;
  localparam logic [31:0] NOP = 32'hD503201F;
  state_t          state_q, state_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     retired_q, retired_d;
  logic            fault_q, fault_d;
  logic [4:0]      sh;
  // State register; reset restarts fetching at RESET_PC even mid-fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      bcnt_q    <= '0;
      pc_q      <= RESET_PC;
      instr_q   <= NOP;
      retired_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
    end
  end
  // Byte bcnt-1 arrives while byte bcnt is being requested
  assign sh = {bcnt_q - 2'd1, 3'b000};
  // Next-state: byte assembly, HALT detection, handshake and PC update
  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    case (state_q)
      FETCH: begin
        if (bcnt_q != 2'd0) instr_d[sh +: 8] = bus.imem_rdata;
        bcnt_d  = bcnt_q + 2'd1;
        state_d = (bcnt_q == 2'd3) ? LAST : FETCH;
      end
      LAST: begin
        instr_d[31:24] = bus.imem_rdata;
        bcnt_d         = 2'd0;
        state_d        = ({bus.imem_rdata, instr_q[23:21]} == 11'h7FF) ? HALT : ISSUE;
      end
      ISSUE: state_d = bus.instr_ready ? WAIT : ISSUE;
      WAIT: begin
        if (bus.ex_done) begin
          retired_d = retired_q + 32'd1;
          if (bus.pc_src && bus.branch_addr[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = HALT;
          end else begin
            pc_d    = bus.pc_src ? bus.branch_addr : pc_q + PC_W'(4);
            bcnt_d  = 2'd0;
            state_d = FETCH;
          end
        end
      end
      default: state_d = HALT;
    endcase
  end
  assign bus.imem_rd     = (state_q == FETCH) && !reset;
  assign bus.imem_addr   = pc_q + PC_W'(bcnt_q);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = pc_q;
  assign bus.instr_valid = (state_q == ISSUE) && !reset;
  assign bus.halted      = (state_q == HALT);
  assign bus.fault       = fault_q;
  assign bus.retired     = retired_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of fetch, branch, halt, fault, backpressure, reset and PC wrap
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset_w = 1'b1;
  int total = 0;
  int bad = 0;
  logic [7:0]  mem [256];
  logic [63:0] rd_f[$];
  logic [63:0] rd_w[$];
  always #5 clk = ~clk;
  fetch_sequencer_if #(.PC_W(64)) f ();
  fetch_sequencer_if #(.PC_W(64)) w ();
  fetch_sequencer #(.PC_W(64), .RESET_PC(64'h0)) u_dut (.clk(clk), .reset(reset), .bus(f.master));
  fetch_sequencer #(.PC_W(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (.clk(clk), .reset(reset_w), .bus(w.master));
  // Byte memory with one-cycle read latency; every performed read is logged
  always @(posedge clk) begin
    f.imem_rdata <= mem[f.imem_addr[7:0]];
    w.imem_rdata <= mem[w.imem_addr[7:0]];
    if (f.imem_rd) rd_f.push_back(f.imem_addr);
    if (w.imem_rd) rd_w.push_back(w.imem_addr);
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wait_valid(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!f.instr_valid && k < 20);
  endtask
  task automatic check_addrs(input string tag, input logic [63:0] base);
    check({tag, "_n"}, rd_f.size(), 4);
    for (int i = 0; i < 4; i++) check(tag, (i < rd_f.size()) ? rd_f[i] : '1, base + i);
    rd_f.delete();
  endtask
  task automatic retire(input logic src, input logic [63:0] tgt);
    @(negedge clk);
    check("valid_drop", f.instr_valid, 0);
    f.ex_done = 1'b1;
    f.pc_src = src;
    f.branch_addr = tgt;
    @(negedge clk);
    f.ex_done = 1'b0;
    f.pc_src = 1'b0;
  endtask
  initial begin
    int k;
    logic saw_v, stable;
    logic [31:0] snap;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    {mem[0], mem[1], mem[2], mem[3]} = {8'h1F, 8'h20, 8'h03, 8'hD5};
    {mem[4], mem[5], mem[6], mem[7]} = {8'h10, 8'h00, 8'h00, 8'h14};
    {mem[8], mem[9], mem[10], mem[11]} = {8'h00, 8'h00, 8'hE0, 8'hFF};
    {mem[64], mem[65], mem[66], mem[67]} = {8'h20, 8'h00, 8'h02, 8'h8B};
    {mem[252], mem[253], mem[254], mem[255]} = {8'h1F, 8'h20, 8'h03, 8'hD5};
    f.instr_ready = 1'b1; f.ex_done = 1'b0; f.pc_src = 1'b0; f.branch_addr = '0;
    w.instr_ready = 1'b1; w.ex_done = 1'b0; w.pc_src = 1'b0; w.branch_addr = '0;
    @(negedge clk);
    check("rst_rd", f.imem_rd, 0);
    check("rst_instr", f.instr, 32'hD503201F);
    check("rst_valid", f.instr_valid, 0);
    check("rst_halted", f.halted, 0);
    check("rst_fault", f.fault, 0);
    check("rst_retired", f.retired, 0);
    check("rst_pc", f.instr_pc, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_valid(k);
    check("lat0", k, 5);
    check("instr0", f.instr, 32'hD503201F);
    check("pc0", f.instr_pc, 0);
    check_addrs("addr0", 64'h0);
    retire(1'b0, 64'h0);
    check("retired1", f.retired, 1);
    wait_valid(k);
    check("lat1", k, 5);
    check("instr1", f.instr, 32'h14000010);
    check("pc1", f.instr_pc, 64'h4);
    check_addrs("addr1", 64'h4);
    retire(1'b1, 64'h40);
    wait_valid(k);
    check("instr2", f.instr, 32'h8B020020);
    check("pc2", f.instr_pc, 64'h40);
    check_addrs("addr2", 64'h40);
    retire(1'b1, 64'h8);
    k = 0;
    saw_v = 1'b0;
    while (!f.halted && k < 20) begin
      @(negedge clk);
      k++;
      saw_v |= f.instr_valid;
    end
    check("halt_lat", k, 5);
    check("halt_valid", saw_v, 0);
    check("halt_instr", f.instr, 32'hFFE00000);
    check("halt_fault", f.fault, 0);
    check("halt_retired", f.retired, 3);
    check_addrs("addr3", 64'h8);
    repeat (3) @(negedge clk);
    f.ex_done = 1'b1;
    @(negedge clk);
    f.ex_done = 1'b0;
    repeat (3) @(negedge clk);
    check("halt_ignore_ex", f.retired, 3);
    check("halt_no_reads", rd_f.size(), 0);
    check("halt_sticky", f.halted, 1);
    check("halt_pc", f.instr_pc, 64'h8);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_valid(k);
    check_addrs("addr_f", 64'h0);
    retire(1'b1, 64'h42);
    check("mis_fault", f.fault, 1);
    check("mis_halted", f.halted, 1);
    check("mis_pc", f.instr_pc, 64'h0);
    check("mis_retired", f.retired, 1);
    repeat (10) @(negedge clk);
    check("mis_no_reads", rd_f.size(), 0);
    check("mis_sticky", f.fault, 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    f.instr_ready = 1'b0;
    reset = 1'b0;
    wait_valid(k);
    check("bp_lat", k, 5);
    check_addrs("addr_bp", 64'h0);
    snap = f.instr;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      stable &= f.instr_valid && (f.instr == snap);
    end
    check("bp_stable", stable, 1);
    check("bp_instr", snap, 32'hD503201F);
    f.instr_ready = 1'b1;
    retire(1'b0, 64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_rd", f.imem_rd, 0);
    check("mid_rst_instr", f.instr, 32'hD503201F);
    check("mid_rst_pc", f.instr_pc, 64'h0);
    check("mid_rst_retired", f.retired, 0);
    check("mid_rst_addr", rd_f.size(), 2);
    rd_f.delete();
    reset = 1'b0;
    wait_valid(k);
    check("restart_lat", k, 5);
    check("restart_instr", f.instr, 32'hD503201F);
    check_addrs("addr_restart", 64'h0);
    reset_w = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!w.instr_valid && k < 20);
    check("wrap_lat", k, 5);
    check("wrap_pc0", w.instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_instr", w.instr, 32'hD503201F);
    check("wrap_addr0", (rd_w.size() > 0) ? rd_w[0] : '0, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_addr3", (rd_w.size() > 3) ? rd_w[3] : '0, 64'hFFFF_FFFF_FFFF_FFFF);
    rd_w.delete();
    @(negedge clk);
    w.ex_done = 1'b1;
    @(negedge clk);
    w.ex_done = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!w.instr_valid && k < 20);
    check("wrap_pc1", w.instr_pc, 64'h0);
    check("wrap_addr_next", (rd_w.size() > 0) ? rd_w[0] : '1, 64'h0);
    check("wrap_retired", w.retired, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multicycle fetch controller for the LEGv8 CPU. It owns the PC and reads each 32-bit instruction from the byte-wide instruction memory, one byte per cycle, assembling the bytes little-endian. It hands the instruction to decode with a valid/ready handshake, waits for execute to finish, then updates the PC from the sequential or branch path. It stops permanently on the HALT encoding or on a misaligned branch target.

## Interface
- PC_W, 64, PC and byte-address width
- RESET_PC, 64'h0, PC value loaded on reset
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_rd  out  1  byte read strobe to instruction memory
- imem_addr  out  PC_W  byte address = PC + byte index
- imem_rdata  in  8  read data; valid exactly one cycle after the imem_rd cycle
- instr  out  32  assembled instruction; meaningful only while instr_valid=1
- instr_pc  out  PC_W  PC of the presented instruction
- instr_valid  out  1  instruction offered to decode
- instr_ready  in  1  decode accepts; transfer when instr_valid & instr_ready
- ex_done  in  1  single-cycle pulse: current instruction finished execute
- pc_src  in  1  qualified by ex_done; 1 = take branch_addr
- branch_addr  in  PC_W  branch target, qualified by ex_done
- halted  out  1  sticky; HALT instruction fetched or fault
- fault  out  1  sticky; misaligned branch target (branch_addr[1:0] != 0)
- retired  out  32  count of completed ex_done handshakes; wraps modulo 2^32

## Operation
- States: FETCH, LAST, ISSUE, WAIT, HALT.
- **Reset** (any state, including mid-fetch). Next cycle:
  - state=FETCH, bcnt=0, PC=RESET_PC.
  - instr=32'hD503201F (NOP).
  - instr_valid=0, imem_rd=0, halted=0, fault=0, retired=0.
- **FETCH** (4 cycles, bcnt 0..3):
  - imem_rd=1, imem_addr=PC+bcnt.
  - When bcnt>0, capture imem_rdata into instr[8*(bcnt-1)+7 : 8*(bcnt-1)].
  - When bcnt=3, go to LAST.
- **LAST** (1 cycle):
  - imem_rd=0. Capture imem_rdata into instr[31:24].
  - Form the word {imem_rdata, instr[23:0]}. If bits [31:21] of that word = 11'h7FF, go to HALT. Otherwise go to ISSUE.
- **ISSUE**: instr_valid=1; instr and instr_pc hold stable. On instr_ready=1, go to WAIT; instr_valid drops the next cycle.
- **WAIT**: on ex_done=1:
  - retired increments.
  - If pc_src=0: PC ← PC+4, modulo 2^PC_W (wraps from all-ones-minus-3 to 0).
  - If pc_src=1 and branch_addr[1:0]=0: PC ← branch_addr.
  - Either of the above: go to FETCH with bcnt=0.
  - If pc_src=1 and branch_addr[1:0]≠0: PC unchanged; fault=1 and halted=1; go to HALT.
- **HALT**: terminal until reset. imem_rd=0, instr_valid=0, PC frozen. ex_done and instr_ready are ignored.
- ex_done outside WAIT is ignored: it does not update the PC or retired.
- instr_pc is the PC latched at FETCH entry.

## Timing
- Fetch latency: FETCH entry to instr_valid=1 is 5 cycles (4 FETCH + 1 LAST).
- Minimum instruction period: 7 cycles, with instr_ready tied high and ex_done arriving in the first WAIT cycle.
- imem_rd is high for exactly 4 consecutive cycles per instruction, with addresses PC, PC+1, PC+2, PC+3.
- halted asserts in the cycle after LAST when HALT is detected, or in the cycle after the faulting ex_done.
- Reset dominates every other input in the same cycle.
- instr_ready held high before ISSUE is harmless; the transfer occurs in the first ISSUE cycle.

## Test plan
- Reset, then memory bytes 00..03 = 1F 20 03 D5, instr_ready=1, ex_done one cycle after the handshake, pc_src=0 → imem_addr sequence 0,1,2,3; instr=32'hD503201F with instr_pc=0; next fetch at PC=4; retired=1.
- Taken branch: instruction at PC=4, ex_done with pc_src=1, branch_addr=64'h40 → next imem_addr sequence 0x40..0x43; instr_pc=64'h40.
- HALT: bytes at PC=8 are 00 00 E0 FF (word FFE00000) → halted=1 one cycle after LAST; instr_valid never rises; imem_rd stays 0; a later ex_done leaves retired unchanged.
- Misaligned target: ex_done with pc_src=1, branch_addr=64'h42 → fault=1, halted=1, PC unchanged, no further reads.
- Backpressure and reset: instr_ready=0 for 10 cycles → instr_valid and instr stay stable; then assert reset in the middle of the next FETCH at bcnt=2 → next cycle imem_rd=0, instr=32'hD503201F, PC=0, and fetching restarts from address 0.
- Wrap: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, ex_done with pc_src=0 → next fetch at address 0.
